// File: rtl/bottle_fill.sv
// Filling stage: counts synchronised pill pulses into bottles, runs the conveyor
// between bottles and flags the batch as full once the bottle target is reached.
module bottle_fill #(
    parameter int unsigned PILL_W      = 8,
    parameter int unsigned BOTTLE_W    = 8,
    parameter int unsigned SWAP_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                isWork,
    input  logic                pillPulse,
    input  logic [PILL_W-1:0]   pillsPerBottle,
    input  logic [BOTTLE_W-1:0] bottleTarget,
    input  logic                clearCounts,
    output logic [PILL_W-1:0]   pillCount,
    output logic [BOTTLE_W-1:0] bottleCount,
    output logic                bottleDone,
    output logic                conveyor,
    output logic                allFull,
    output logic                spillErr
);

    localparam int unsigned TMR_W = $clog2(SWAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        FULL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [PILL_W-1:0]   pill_cnt_q, pill_cnt_d;
    logic [BOTTLE_W-1:0] bottle_cnt_q, bottle_cnt_d;
    logic [PILL_W-1:0]   ppb_q, ppb_d;
    logic [BOTTLE_W-1:0] tgt_q, tgt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                done_q, done_d;
    logic                conv_q, conv_d;
    logic                full_q, full_d;
    logic                spill_q, spill_d;

    logic                pill_evt_c;
    logic [PILL_W:0]     pill_nxt_c;
    logic [BOTTLE_W:0]   bottle_nxt_c;

    // Rising edge of the pill sensor after a two-flop synchroniser
    assign pill_evt_c   = s2_q & ~s3_q;
    assign pill_nxt_c   = {1'b0, pill_cnt_q} + {{PILL_W{1'b0}}, 1'b1};
    assign bottle_nxt_c = {1'b0, bottle_cnt_q} + {{BOTTLE_W{1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pill_cnt_q   <= '0;
            bottle_cnt_q <= '0;
            ppb_q        <= '0;
            tgt_q        <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            conv_q       <= 1'b0;
            full_q       <= 1'b0;
            spill_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= pillPulse;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pill_cnt_q   <= pill_cnt_d;
            bottle_cnt_q <= bottle_cnt_d;
            ppb_q        <= ppb_d;
            tgt_q        <= tgt_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            conv_q       <= conv_d;
            full_q       <= full_d;
            spill_q      <= spill_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pill_cnt_d   = pill_cnt_q;
        bottle_cnt_d = bottle_cnt_q;
        ppb_d        = ppb_q;
        tgt_d        = tgt_q;
        timer_d      = timer_q;
        done_d       = 1'b0;
        spill_d      = spill_q;

        case (state_q)
            IDLE: begin
                if (isWork) begin
                    state_d = FILL;
                    ppb_d   = (pillsPerBottle == '0) ? PILL_W'(1) : pillsPerBottle;
                    tgt_d   = (bottleTarget == '0) ? BOTTLE_W'(1) : bottleTarget;
                end
            end
            FILL: begin
                // A pill arriving as isWork falls is still counted before pausing
                if (pill_evt_c) begin
                    if (pill_nxt_c < {1'b0, ppb_q}) begin
                        pill_cnt_d = pill_nxt_c[PILL_W-1:0];
                        if (!isWork) begin
                            state_d = IDLE;
                        end
                    end else begin
                        pill_cnt_d   = '0;
                        bottle_cnt_d = bottle_nxt_c[BOTTLE_W-1:0];
                        done_d       = 1'b1;
                        if (bottle_nxt_c == {1'b0, tgt_q}) begin
                            state_d = FULL;
                        end else begin
                            state_d = SWAP;
                            timer_d = TMR_W'(SWAP_CYCLES - 1);
                        end
                    end
                end else if (!isWork) begin
                    state_d = IDLE;
                end
            end
            SWAP: begin
                if (pill_evt_c) begin
                    spill_d = 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = isWork ? FILL : IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            FULL: begin
                if (pill_evt_c) begin
                    spill_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clearCounts) begin
            state_d      = IDLE;
            pill_cnt_d   = '0;
            bottle_cnt_d = '0;
            spill_d      = 1'b0;
            done_d       = 1'b0;
        end

        conv_d = (state_d == SWAP);
        // allFull trails the final bottleDone by one cycle
        full_d = (state_q == FULL) && !clearCounts;
    end

    assign pillCount   = pill_cnt_q;
    assign bottleCount = bottle_cnt_q;
    assign bottleDone  = done_q;
    assign conveyor    = conv_q;
    assign allFull     = full_q;
    assign spillErr    = spill_q;

endmodule

// File: tb/tb_bottle_fill.sv
// Self-checking bench for bottle_fill: directed scenarios plus randomised batches
// compared against a pill/bottle arithmetic model.
module tb_bottle_fill;

    localparam int unsigned PILL_W      = 8;
    localparam int unsigned BOTTLE_W    = 8;
    localparam int unsigned SWAP_CYCLES = 16;

    logic                CLK         = 1'b0;
    logic                RST_N       = 1'b0;
    logic                isWork      = 1'b0;
    logic                pillPulse   = 1'b0;
    logic                clearCounts = 1'b0;
    logic [PILL_W-1:0]   pillsPerBottle = '0;
    logic [BOTTLE_W-1:0] bottleTarget   = '0;
    logic [PILL_W-1:0]   pillCount;
    logic [BOTTLE_W-1:0] bottleCount;
    logic                bottleDone;
    logic                conveyor;
    logic                allFull;
    logic                spillErr;

    bottle_fill #(
        .PILL_W     (PILL_W),
        .BOTTLE_W   (BOTTLE_W),
        .SWAP_CYCLES(SWAP_CYCLES)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .isWork        (isWork),
        .pillPulse     (pillPulse),
        .pillsPerBottle(pillsPerBottle),
        .bottleTarget  (bottleTarget),
        .clearCounts   (clearCounts),
        .pillCount     (pillCount),
        .bottleCount   (bottleCount),
        .bottleDone    (bottleDone),
        .conveyor      (conveyor),
        .allFull       (allFull),
        .spillErr      (spillErr)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Output observers sampled mid-cycle
    int   done_cnt = 0;
    int   conv_cnt = 0;
    int   max_pill = 0;
    int   cyc_n    = 0;
    int   done_at  = -1;
    int   full_at  = -1;
    logic full_prev = 1'b0;

    always @(negedge CLK) begin
        cyc_n = cyc_n + 1;
        if (bottleDone === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_at  = cyc_n;
        end
        if (conveyor === 1'b1) conv_cnt = conv_cnt + 1;
        if (int'(pillCount) > max_pill) max_pill = int'(pillCount);
        if (allFull === 1'b1 && full_prev !== 1'b1) full_at = cyc_n;
        full_prev = allFull;
    end

    // Reference model: pills, bottles and batch state as plain numbers
    int m_pill, m_bottle, m_ppb, m_tgt, m_done, m_conv;
    bit m_full, m_spill;

    task automatic model_clear();
        m_pill = 0; m_bottle = 0; m_full = 0; m_spill = 0;
        m_done = 0; m_conv = 0;
        done_cnt = 0; conv_cnt = 0; max_pill = 0;
    endtask

    task automatic model_latch(input int ppb, input int tgt);
        m_ppb = (ppb == 0) ? 1 : ppb;
        m_tgt = (tgt == 0) ? 1 : tgt;
    endtask

    // where: 0 = bottle under chute, 1 = conveyor moving, 2 = paused
    task automatic model_pill(input int where, output bit swap_follows);
        swap_follows = 0;
        if (m_full || where == 1) begin
            m_spill = 1;
        end else if (where == 0) begin
            m_pill = m_pill + 1;
            if (m_pill == m_ppb) begin
                m_pill   = 0;
                m_bottle = m_bottle + 1;
                m_done   = m_done + 1;
                if (m_bottle == m_tgt) begin
                    m_full = 1;
                end else begin
                    m_conv       = m_conv + SWAP_CYCLES;
                    swap_follows = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic pill(input int hi, input int lo);
        pillPulse = 1'b1;
        cyc(hi);
        pillPulse = 1'b0;
        cyc(lo);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pillCount"},   64'(pillCount),   64'(m_pill));
        chk({tag, ".bottleCount"}, 64'(bottleCount), 64'(m_bottle));
        chk({tag, ".allFull"},     64'(allFull),     64'(m_full));
        chk({tag, ".spillErr"},    64'(spillErr),    64'(m_spill));
    endtask

    task automatic do_clear();
        isWork      = 1'b0;
        clearCounts = 1'b1;
        cyc(1);
        clearCounts = 1'b0;
        model_clear();
    endtask

    bit sw;
    int d0;

    initial begin
        model_clear();
        m_ppb = 1; m_tgt = 1;

        // Reset values
        cyc(2);
        chk("rst.pillCount",   64'(pillCount),   64'd0);
        chk("rst.bottleCount", 64'(bottleCount), 64'd0);
        chk("rst.bottleDone",  64'(bottleDone),  64'd0);
        chk("rst.conveyor",    64'(conveyor),    64'd0);
        chk("rst.allFull",     64'(allFull),     64'd0);
        chk("rst.spillErr",    64'(spillErr),    64'd0);
        RST_N = 1'b1;
        cyc(1);

        // Three pills fill one bottle, then a full conveyor swap
        pillsPerBottle = 8'd3; bottleTarget = 8'd2; isWork = 1'b1;
        cyc(1);
        model_latch(3, 2);
        pill(2, 2); model_pill(0, sw); chk("p1.pill1", 64'(pillCount), 64'(m_pill));
        pill(2, 2); model_pill(0, sw); chk("p1.pill2", 64'(pillCount), 64'(m_pill));
        pill(2, 2); model_pill(0, sw); check_all("p1.bottle1");
        chk("p1.done_pulses", 64'(done_cnt), 64'(m_done));
        cyc(SWAP_CYCLES + 2);
        chk("p1.conv_cycles", 64'(conv_cnt), 64'(m_conv));

        // Second bottle completes the batch; no conveyor, allFull one cycle later
        repeat (3) begin pill(2, 2); model_pill(0, sw); end
        isWork = 1'b0;
        cyc(SWAP_CYCLES + 2);
        check_all("p2.full");
        chk("p2.full_lag",    64'(full_at - done_at), 64'd1);
        chk("p2.conv_cycles", 64'(conv_cnt), 64'(m_conv));
        chk("p2.done_pulses", 64'(done_cnt), 64'(m_done));
        pill(2, 2); model_pill(0, sw);
        check_all("p2.spill_full");
        do_clear();
        check_all("p2.clear");

        // Pill while the conveyor runs is a spill, not a count
        pillsPerBottle = 8'd1; bottleTarget = 8'd3; isWork = 1'b1;
        cyc(1);
        model_latch(1, 3);
        pill(2, 2); model_pill(0, sw);
        pill(2, 2); model_pill(1, sw);
        check_all("p3.mid_swap");
        chk("p3.conveyor", 64'(conveyor), 64'd1);
        do_clear();
        check_all("p3.clear");
        chk("p3.clear_conv", 64'(conveyor), 64'd0);
        pill(2, 2); model_pill(2, sw);
        check_all("p3.idle_ignore");

        // Zero limits behave as one
        pillsPerBottle = 8'd0; bottleTarget = 8'd0; isWork = 1'b1;
        cyc(1);
        model_latch(0, 0);
        pill(2, 2); model_pill(0, sw);
        cyc(2);
        check_all("p4.zero_limits");
        chk("p4.full_lag", 64'(full_at - done_at), 64'd1);
        do_clear();

        // Largest bottle: 255 pills, count peaks at 254
        pillsPerBottle = 8'd255; bottleTarget = 8'd1; isWork = 1'b1;
        cyc(1);
        model_latch(255, 1);
        repeat (254) begin pill(2, 2); model_pill(0, sw); end
        check_all("p4.pill254");
        pill(2, 2); model_pill(0, sw);
        cyc(2);
        check_all("p4.pill255");
        chk("p4.max_pill", 64'(max_pill), 64'd254);
        do_clear();

        // Pause and resume keeps the partial bottle
        pillsPerBottle = 8'd5; bottleTarget = 8'd2; isWork = 1'b1;
        cyc(1);
        model_latch(5, 2);
        repeat (2) begin pill(2, 2); model_pill(0, sw); end
        isWork = 1'b0;
        cyc(3);
        check_all("p5.paused");
        pill(2, 2); model_pill(2, sw);
        check_all("p5.paused_pill");
        isWork = 1'b1;
        cyc(1);
        d0 = done_cnt;
        repeat (3) begin pill(2, 2); model_pill(0, sw); end
        check_all("p5.resumed");
        chk("p5.done_pulse", 64'(done_cnt - d0), 64'd1);
        cyc(SWAP_CYCLES + 2);
        // Pill event lands on the same edge that sees isWork low
        pillPulse = 1'b1;
        cyc(2);
        isWork = 1'b0;
        cyc(1);
        pillPulse = 1'b0;
        cyc(2);
        model_pill(0, sw);
        check_all("p5.coincident");
        pill(2, 2); model_pill(2, sw);
        check_all("p5.after_coincident");
        do_clear();

        // Asynchronous reset in the middle of a swap
        pillsPerBottle = 8'd1; bottleTarget = 8'd3; isWork = 1'b1;
        cyc(1);
        model_latch(1, 3);
        pill(2, 2); model_pill(0, sw);
        cyc(2);
        chk("p6.pre_rst_conv", 64'(conveyor), 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("p6.rst_conveyor",    64'(conveyor),    64'd0);
        chk("p6.rst_bottleCount", 64'(bottleCount), 64'd0);
        chk("p6.rst_pillCount",   64'(pillCount),   64'd0);
        chk("p6.rst_spill_full",  64'({spillErr, allFull, bottleDone}), 64'd0);
        isWork = 1'b0;
        cyc(1);
        RST_N = 1'b1;
        model_clear();
        cyc(1);

        // Two-cycle pulse counts once, updating on the third edge
        pillsPerBottle = 8'd3; bottleTarget = 8'd2; isWork = 1'b1;
        cyc(1);
        model_latch(3, 2);
        pillPulse = 1'b1;
        cyc(1); chk("p6.edge1", 64'(pillCount), 64'd0);
        cyc(1); chk("p6.edge2", 64'(pillCount), 64'd0);
        pillPulse = 1'b0;
        cyc(1); chk("p6.edge3", 64'(pillCount), 64'd1);
        cyc(4); chk("p6.once",  64'(pillCount), 64'd1);
        do_clear();

        // Randomised batches against the model
        for (int b = 0; b < 6; b++) begin
            int ppb_r, tgt_r;
            ppb_r = int'($urandom_range(0, 4));
            tgt_r = int'($urandom_range(0, 3));
            pillsPerBottle = PILL_W'(ppb_r);
            bottleTarget   = BOTTLE_W'(tgt_r);
            isWork = 1'b1;
            cyc(1);
            model_latch(ppb_r, tgt_r);
            for (int p = 0; p < 64 && !m_full; p++) begin
                pill(int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
                model_pill(0, sw);
                chk("rnd.pillCount",   64'(pillCount),   64'(m_pill));
                chk("rnd.bottleCount", 64'(bottleCount), 64'(m_bottle));
                if (sw) cyc(SWAP_CYCLES + int'($urandom_range(2, 5)));
            end
            cyc(2);
            check_all("rnd.batch_end");
            chk("rnd.done_pulses", 64'(done_cnt), 64'(m_done));
            chk("rnd.conv_cycles", 64'(conv_cnt), 64'(m_conv));
            if ($urandom_range(0, 1) == 1) begin
                pill(2, 2); model_pill(0, sw);
                check_all("rnd.extra_pill");
            end
            do_clear();
            check_all("rnd.clear");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
